// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Instruction fetch front end of the RV32I core. It owns the program
//   counter and drives fetch addresses into a synchronous-read instruction
//   memory. Decode back-pressure is absorbed by holding the memory read
//   (l_pause). Instructions are handed to decode over a valid/ready
//   handshake. The unit applies static JAL-taken prediction and accepts PC
//   redirects from execute.
//
// Parameters
//   RESET_PC  PC loaded on reset (word-aligned)
//   PRED_EN   1: predict JAL taken, 0: always step by PC+4
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   mem_addr        fetch byte address (bits [1:0] = 0)
//   mem_addrpred    copy of mem_addr
//   mem_renable     read enable (!rst)
//   l_pause         memory read hold
//   mem_rdata       word for the previous non-paused address
//   mem_rdata_pred  reserved, ignored
//   if_valid/if_ready/if_instr/if_pc/if_pred_taken  decode handshake
//   redirect_valid, redirect_pc  execute-stage PC correction
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter bit          PRED_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_addrpred,
  output logic        mem_renable,
  output logic        l_pause,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] mem_rdata_pred,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_pred_taken,
  input  logic        if_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  logic [31:0] fetch_pc;
  logic [31:0] resp_pc;
  logic        resp_valid;

  logic        is_jal;
  logic [31:0] jal_offset;
  logic [31:0] jal_target;
  logic        unused_pred;

  assign unused_pred = ^mem_rdata_pred;

  assign mem_addr     = fetch_pc;
  assign mem_addrpred = fetch_pc;
  assign mem_renable  = !rst;

  assign if_instr = mem_rdata;
  assign if_pc    = resp_pc;

  // Offer and pause are also masked during reset, so decode never consumes
  // an instruction that the reset edge is about to discard.
  assign if_valid = resp_valid && !redirect_valid && !rst;
  assign l_pause  = resp_valid && !if_ready && !redirect_valid && !rst;

  assign is_jal        = (if_instr[6:0] == 7'b1101111) && PRED_EN;
  assign if_pred_taken = is_jal && if_valid;

  assign jal_offset = {{12{if_instr[31]}}, if_instr[19:12], if_instr[20],
                       if_instr[30:21], 1'b0};
  assign jal_target = resp_pc + jal_offset;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc   <= {RESET_PC[31:2], 2'b00};
      resp_pc    <= {RESET_PC[31:2], 2'b00};
      resp_valid <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc   <= {redirect_pc[31:2], 2'b00};
      resp_valid <= 1'b0;
    end else if (l_pause) begin
      fetch_pc   <= fetch_pc;
      resp_valid <= resp_valid;
    end else if (if_valid && is_jal) begin
      // The word fetched at resp_pc+4 arrives next cycle and is squashed
      // by clearing resp_valid.
      fetch_pc   <= jal_target;
      resp_valid <= 1'b0;
    end else begin
      resp_pc    <= fetch_pc;
      resp_valid <= 1'b1;
      fetch_pc   <= fetch_pc + 32'd4;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic [31:0] mem_addr, mem_addrpred, mem_rdata, if_instr, if_pc;
  logic        mem_renable, l_pause, if_valid, if_pred_taken;

  logic [31:0] np_mem_addr, np_mem_addrpred, np_mem_rdata, np_if_instr, np_if_pc;
  logic        np_mem_renable, np_l_pause, np_if_valid, np_if_pred_taken;

  int vectors = 0;
  int errors  = 0;

  localparam logic [31:0] JAL_P16 = 32'h0100_006F;  // jal x0,+16
  localparam logic [31:0] JAL_M8  = 32'hFF9F_F06F;  // jal x0,-8

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h108 || a == 32'h404) return JAL_P16;
    if (a == 32'h4) return JAL_M8;
    return {a[23:0], 8'h13};
  endfunction

  // Synchronous-read memory with read hold.
  always @(posedge clk) if (mem_renable && !l_pause) mem_rdata <= memf(mem_addr);
  always @(posedge clk) if (np_mem_renable && !np_l_pause) np_mem_rdata <= memf(np_mem_addr);

  instr_fetch_unit #(.RESET_PC(32'h0000_0100), .PRED_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .mem_addr(mem_addr), .mem_addrpred(mem_addrpred), .mem_renable(mem_renable),
    .l_pause(l_pause), .mem_rdata(mem_rdata), .mem_rdata_pred(32'h0),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_pred_taken(if_pred_taken), .if_ready(if_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  instr_fetch_unit #(.RESET_PC(32'h0000_0100), .PRED_EN(1'b0)) u_dut_np (
    .clk(clk), .rst(rst),
    .mem_addr(np_mem_addr), .mem_addrpred(np_mem_addrpred), .mem_renable(np_mem_renable),
    .l_pause(np_l_pause), .mem_rdata(np_mem_rdata), .mem_rdata_pred(32'h0),
    .if_valid(np_if_valid), .if_instr(np_if_instr), .if_pc(np_if_pc),
    .if_pred_taken(np_if_pred_taken), .if_ready(1'b1),
    .redirect_valid(1'b0), .redirect_pc(32'h0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; if_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    cyc(); cyc(); settle();
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_l_pause", {31'b0, l_pause}, 32'd0);
    chk("rst_renable", {31'b0, mem_renable}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h100);
    chk("rst_addrpred", mem_addrpred, 32'h100);
    chk("rst_if_pc", if_pc, 32'h100);
    chk("rst_pred", {31'b0, if_pred_taken}, 32'd0);

    // cycle 0: reset released
    rst = 1'b0; settle();
    chk("c0_mem_addr", mem_addr, 32'h100);
    chk("c0_renable", {31'b0, mem_renable}, 32'd1);
    chk("c0_if_valid", {31'b0, if_valid}, 32'd0);

    // cycle 1: first instruction
    cyc(); settle();
    chk("c1_if_valid", {31'b0, if_valid}, 32'd1);
    chk("c1_if_pc", if_pc, 32'h100);
    chk("c1_if_instr", if_instr, 32'h0001_0013);
    chk("c1_mem_addr", mem_addr, 32'h104);

    // cycles 2-4: stall at 0x104
    for (int k = 0; k < 3; k++) begin
      cyc(); if_ready = 1'b0; settle();
      chk("stall_l_pause", {31'b0, l_pause}, 32'd1);
      chk("stall_if_pc", if_pc, 32'h104);
      chk("stall_if_instr", if_instr, 32'h0001_0413);
      chk("stall_mem_addr", mem_addr, 32'h108);
      if (k == 1) begin  // cycle 3: non-predicting instance offers the JAL
        chk("np_jal_pc", np_if_pc, 32'h108);
        chk("np_jal_instr", np_if_instr, JAL_P16);
        chk("np_jal_pred", {31'b0, np_if_pred_taken}, 32'd0);
      end
      if (k == 2) begin  // cycle 4: it steps to PC+4
        chk("np_next_valid", {31'b0, np_if_valid}, 32'd1);
        chk("np_next_pc", np_if_pc, 32'h10C);
      end
    end

    // cycle 5: ready back, 0x104 still offered and now accepted
    cyc(); if_ready = 1'b1; settle();
    chk("rel_if_pc", if_pc, 32'h104);
    chk("rel_l_pause", {31'b0, l_pause}, 32'd0);

    // cycle 6: JAL at 0x108
    cyc(); settle();
    chk("jal_if_pc", if_pc, 32'h108);
    chk("jal_instr", if_instr, JAL_P16);
    chk("jal_pred", {31'b0, if_pred_taken}, 32'd1);

    // cycle 7: bubble, target presented
    cyc(); settle();
    chk("jal_bubble", {31'b0, if_valid}, 32'd0);
    chk("jal_mem_addr", mem_addr, 32'h118);

    // cycle 8: target offered; redirect to 0x200 in the same cycle
    cyc(); settle();
    chk("jal_tgt_valid", {31'b0, if_valid}, 32'd1);
    chk("jal_tgt_pc", if_pc, 32'h118);
    chk("jal_tgt_instr", if_instr, 32'h0001_1813);
    redirect_valid = 1'b1; redirect_pc = 32'h200; settle();
    chk("rd_if_valid", {31'b0, if_valid}, 32'd0);

    // cycle 9
    cyc(); redirect_valid = 1'b0; settle();
    chk("rd_mem_addr", mem_addr, 32'h200);
    chk("rd_bubble", {31'b0, if_valid}, 32'd0);

    // cycle 10: 0x200 offered, decode stalls
    cyc(); if_ready = 1'b0; settle();
    chk("rd_if_pc", if_pc, 32'h200);
    chk("s200_l_pause", {31'b0, l_pause}, 32'd1);

    // cycle 11: redirect during stall
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h403; settle();
    chk("rds_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rds_l_pause", {31'b0, l_pause}, 32'd0);

    // cycle 12
    cyc(); redirect_valid = 1'b0; if_ready = 1'b1; settle();
    chk("rds_mem_addr", mem_addr, 32'h400);

    // cycle 13
    cyc(); settle();
    chk("rds_if_pc", if_pc, 32'h400);
    chk("rds_instr", if_instr, 32'h0004_0013);

    // cycle 14: JAL at 0x404 offered with a redirect to 0x80
    cyc(); settle();
    chk("rj_instr", if_instr, JAL_P16);
    redirect_valid = 1'b1; redirect_pc = 32'h80; settle();
    chk("rj_if_valid", {31'b0, if_valid}, 32'd0);

    // cycle 15
    cyc(); redirect_valid = 1'b0; settle();
    chk("rj_mem_addr", mem_addr, 32'h80);

    // cycle 16: redirect to the top of the address space
    cyc(); settle();
    chk("rj_if_pc", if_pc, 32'h80);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; settle();

    // cycle 17
    cyc(); redirect_valid = 1'b0; settle();
    chk("wr_mem_addr", mem_addr, 32'hFFFF_FFFC);

    // cycle 18
    cyc(); settle();
    chk("wr_if_pc", if_pc, 32'hFFFF_FFFC);
    chk("wr_addr_wrap", mem_addr, 32'h0);

    // cycle 19
    cyc(); settle();
    chk("wr_if_pc0", if_pc, 32'h0);
    chk("wr_instr0", if_instr, 32'h0000_0013);

    // cycle 20: backward JAL at 0x4, target wraps below zero
    cyc(); settle();
    chk("bj_if_pc", if_pc, 32'h4);
    chk("bj_pred", {31'b0, if_pred_taken}, 32'd1);

    // cycle 21
    cyc(); settle();
    chk("bj_bubble", {31'b0, if_valid}, 32'd0);
    chk("bj_mem_addr", mem_addr, 32'hFFFF_FFFC);

    // cycle 22
    cyc(); settle();
    chk("bj_tgt_pc", if_pc, 32'hFFFF_FFFC);

    // cycle 23: reset mid-stream for one cycle
    cyc(); rst = 1'b1; settle();
    chk("mr_if_valid", {31'b0, if_valid}, 32'd0);
    chk("mr_renable", {31'b0, mem_renable}, 32'd0);

    // cycle 24
    cyc(); rst = 1'b0; settle();
    chk("mr_after_valid", {31'b0, if_valid}, 32'd0);
    chk("mr_mem_addr", mem_addr, 32'h100);

    // cycle 25
    cyc(); settle();
    chk("mr_if_valid2", {31'b0, if_valid}, 32'd1);
    chk("mr_if_pc", if_pc, 32'h100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
